// File: rtl/operand_select_stage.sv
// operand_select_stage -- N:1 word selector with a registered valid/ready
// output stage. The selected word is held across back-pressure, and strict
// FIFO ordering is kept.
//
// Build option: define OPSEL_SKID_EN to get a 2-entry skid buffer with a
// registered in_ready. Without it the design is a single register stage with
// a combinational in_ready.
//
// Parameters
//   WIDTH   data word width
//   NUM_IN  number of input lanes (>= 2)
//   SEL_W   derived select width, max(1, $clog2(NUM_IN)); not overridable
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake; sel and data_in are sampled on accept
//   sel                 lane index; lane k = data_in[k*WIDTH +: WIDTH]
//   data_in             flattened input lanes
//   out_valid/out_ready downstream handshake
//   out_data            registered selected word
//   sel_err             sticky flag, set when an accepted sel >= NUM_IN
//   clr_err             synchronous clear of sel_err; a set in the same cycle wins

// Per-lane select: passes its lane through only when it is addressed.
module operand_select_lane #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] lane,
  output logic [WIDTH-1:0] masked
);
  assign masked = (sel == SEL_W'(IDX)) ? lane : '0;
endmodule

module operand_select_stage #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_err,
  input  logic                    clr_err
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  // The encoding lets out_valid (bit 0) and the SKID-mode in_ready (~bit 1)
  // come straight off state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  // Lane mux: OR of masked lanes. An out-of-range select matches no lane, so
  // the word falls to zero without extra logic.
  logic [NUM_IN-1:0][WIDTH-1:0] masked;
  logic [WIDTH-1:0]             sel_word;
  logic                         sel_oor;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
    operand_select_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
      .sel    (sel),
      .lane   (data_in[k*WIDTH +: WIDTH]),
      .masked (masked[k])
    );
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) sel_word |= masked[k];
  end

  assign sel_oor = ({1'b0, sel} >= NUM_IN_W);

  logic accept, pop, load_main;

  assign out_valid = state_q[0];
`ifdef OPSEL_SKID_EN
  assign in_ready  = ~state_q[1];
`else
  assign in_ready  = ~state_q[0] | out_ready;
`endif
  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

`ifdef OPSEL_SKID_EN
  logic             load_skid, skid_to_main;
  logic [WIDTH-1:0] skid_q;
`endif

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
`ifdef OPSEL_SKID_EN
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
`endif
    case (state_q)
      EMPTY: if (accept) begin
        state_d   = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        // Pass-through: the old word leaves and the new one takes its place.
        if (accept && pop) load_main = 1'b1;
`ifdef OPSEL_SKID_EN
        else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end
`endif
        else if (pop) state_d = EMPTY;
      end
`ifdef OPSEL_SKID_EN
      // in_ready is low here, so only a drain can happen.
      FULL: if (pop) begin
        state_d      = ONE;
        skid_to_main = 1'b1;
      end
`endif
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) out_data <= sel_word;
`ifdef OPSEL_SKID_EN
      else if (skid_to_main) out_data <= skid_q;
`endif
    end
  end

`ifdef OPSEL_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         skid_q <= '0;
    else if (load_skid) skid_q <= sel_word;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sel_err <= 1'b0;
    else if (accept && sel_oor) sel_err <= 1'b1;
    else if (clr_err)           sel_err <= 1'b0;
  end

endmodule

// File: tb/tb_operand_select_stage.sv
// Bench for operand_select_stage. A 4-lane instance is checked every cycle
// against a queue model. A 3-lane instance covers out-of-range selects and
// the sticky error flag.
module tb_operand_select_stage;
`ifdef OPSEL_SKID_EN
  localparam int MAXOCC = 2;
`else
  localparam int MAXOCC = 1;
`endif
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-lane instance
  logic           in_valid, in_ready, out_valid, out_ready, sel_err, clr_err;
  logic [1:0]     sel;
  logic [4*W-1:0] data_in;
  logic [W-1:0]   out_data;

  // 3-lane instance
  logic           in3_valid, in3_ready, out3_valid, out3_ready, serr3, clr3;
  logic [1:0]     sel3;
  logic [3*W-1:0] data3;
  logic [W-1:0]   out3_data;

  operand_select_stage #(.WIDTH(W), .NUM_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_err(sel_err), .clr_err(clr_err)
  );

  operand_select_stage #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in3_valid), .in_ready(in3_ready),
    .sel(sel3), .data_in(data3), .out_valid(out3_valid), .out_ready(out3_ready),
    .out_data(out3_data), .sel_err(serr3), .clr_err(clr3)
  );

  int n_chk = 0, n_pass = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] sb[$];
  logic [W-1:0] obs[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] lane_of(logic [1:0] s, logic [4*W-1:0] d);
    return d[s*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One cycle; reports whether the input handshake fires on this edge.
  task automatic cyc(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk); #1;
  endtask

  // Scoreboard: the queue holds the words the stage should currently own.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) chk("out_data", out_data, sb[0]);
`ifdef OPSEL_SKID_EN
      chk("in_ready", in_ready, sb.size() < 2);
`else
      chk("in_ready", in_ready, (sb.size() == 0) || out_ready);
`endif
      chk("sel_err4", sel_err, 0);
      if (out_valid && out_ready && sb.size() != 0) begin
        obs.push_back(out_data);
        void'(sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(lane_of(sel, data_in));
    end
  end

  logic [W-1:0] lane_exp [4];
  logic [W-1:0] wd;
  bit acc;
  int nacc;

  initial begin
    lane_exp[0] = 32'h11111111; lane_exp[1] = 32'h22222222;
    lane_exp[2] = 32'h33333333; lane_exp[3] = 32'h44444444;
    in_valid = 0; out_ready = 0; sel = 0; data_in = '0; clr_err = 0;
    in3_valid = 0; out3_ready = 1; sel3 = 0; data3 = '0; clr3 = 0;

    // reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_in_ready", in_ready, 1);
    #9 rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // lane select, back-to-back
    data_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    out_ready = 1; obs.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; sel = 2'(i); tick();
    end
    in_valid = 0; tick(); tick();
    chk("lane_cnt", obs.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("lane_seq", (i < obs.size()) ? obs[i] : 32'hx, lane_exp[i]);

    // back-pressure
    out_ready = 0; obs.delete(); nacc = 0; wd = 32'hA0000000;
    in_valid = 1; sel = 0; data_in = '0; data_in[W-1:0] = wd;
    for (int i = 0; i < 4; i++) begin
      cyc(acc);
      if (acc) begin nacc++; wd = wd + 1; data_in[W-1:0] = wd; end
    end
    chk("bp_accepts", nacc, MAXOCC);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    repeat (4) tick();
    chk("bp_drain_cnt", obs.size(), MAXOCC);
    for (int i = 0; i < MAXOCC; i++)
      chk("bp_order", (i < obs.size()) ? obs[i] : 32'hx, 32'hA0000000 + i);

    // reset mid-stream
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      sel = 2'(i); wd = 32'hB0000000 + i; data_in = {wd, wd, wd, wd}; tick();
    end
    #2 rst_n = 1'b0; in_valid = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_sel_err", sel_err, 0);
    sb.delete();
    #4 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", out_valid, 0);
    sel = 2'd2; data_in = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; in_valid = 1;
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 32'hD2);
    in_valid = 0; tick();

    // random stress
    acc = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        sel = 2'($urandom_range(0, 3));
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = 1'($urandom_range(0, 1));
      cyc(acc);
    end
    in_valid = 0; out_ready = 1;
    repeat (4) tick();
    chk("stress_drained", sb.size(), 0);
    chk("stress_idle", out_valid, 0);

    // out-of-range select on the 3-lane instance
    data3 = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    in3_valid = 1; sel3 = 2'd3; tick();
    chk("oor_valid", out3_valid, 1);
    chk("oor_data", out3_data, 0);
    chk("oor_err_set", serr3, 1);
    in3_valid = 0; tick(); tick();
    chk("oor_err_sticky", serr3, 1);
    in3_valid = 1; sel3 = 2'd1; tick();
    chk("good_data", out3_data, 32'hBBBBBBBB);
    chk("good_err_holds", serr3, 1);
    in3_valid = 0; clr3 = 1; tick();
    chk("err_cleared", serr3, 0);
    clr3 = 0; sel3 = 2'd3; tick();
    chk("idle_bad_sel_ignored", serr3, 0);
    in3_valid = 1; clr3 = 1; tick();
    chk("set_beats_clear", serr3, 1);
    in3_valid = 0; clr3 = 0; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
